// File: rtl/mem_ctrl_if.sv
// Core request/response and RAM pin bundle for mem_ctrl.
// slave = controller side, master = core + RAM side.
interface mem_ctrl_if;
   logic       req;
   logic       req_wr;
   logic       req_fetch2;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata0;
   logic [7:0] rdata1;
   logic       mem_cs;
   logic       mem_wr;
   logic [7:0] mem_addr;
   logic [7:0] mem_din;
   logic [7:0] mem_dout;

   modport master (
      output req, req_wr, req_fetch2, req_addr, req_wdata, mem_dout,
      input  busy, done, rdata0, rdata1, mem_cs, mem_wr, mem_addr, mem_din
   );

   modport slave (
      input  req, req_wr, req_fetch2, req_addr, req_wdata, mem_dout,
      output busy, done, rdata0, rdata1, mem_cs, mem_wr, mem_addr, mem_din
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte RAM access controller: single write, single read, optional two-byte fetch.
// Define MEM_CTRL_FETCH2_EN to enable the fetch2 (opcode+operand) read.
module mem_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   mem_ctrl_if.slave   bus
);

`ifdef MEM_CTRL_FETCH2_EN
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, RD2_WAIT, RD2_CAP, WR_DONE} state_e;
`else
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WR_DONE} state_e;
`endif

   state_e     state_q, state_d;
   logic       cs_q, cs_d;
   logic       wr_q, wr_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] din_q, din_d;
   logic [7:0] rdata0_q, rdata0_d;
   logic       done_q, done_d;
   logic       busy_q;
`ifdef MEM_CTRL_FETCH2_EN
   logic       fetch2_q, fetch2_d;
   logic [7:0] rdata1_q, rdata1_d;
`else
   logic       unused_fetch2;
   assign unused_fetch2 = bus.req_fetch2;
`endif

   always_comb begin
      state_d  = state_q;
      cs_d     = cs_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rdata0_d = rdata0_q;
      done_d   = 1'b0;
`ifdef MEM_CTRL_FETCH2_EN
      fetch2_d = fetch2_q;
      rdata1_d = rdata1_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req) begin
               cs_d   = 1'b0;
               addr_d = bus.req_addr;
               if (bus.req_wr) begin
                  wr_d    = 1'b0;
                  din_d   = bus.req_wdata;
                  state_d = WR_DONE;
               end else begin
                  wr_d    = 1'b1;
                  state_d = RD_WAIT;
`ifdef MEM_CTRL_FETCH2_EN
                  fetch2_d = bus.req_fetch2;
`endif
               end
            end
         end
         WR_DONE: begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         RD_WAIT: state_d = RD_CAP;
         RD_CAP: begin
            rdata0_d = bus.mem_dout;
`ifdef MEM_CTRL_FETCH2_EN
            // Keep CS low and step to the operand byte; address wraps at 0xFF.
            if (fetch2_q) begin
               addr_d  = addr_q + 8'd1;
               state_d = RD2_WAIT;
            end else
`endif
            begin
               cs_d    = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
`ifdef MEM_CTRL_FETCH2_EN
         RD2_WAIT: state_d = RD2_CAP;
         RD2_CAP: begin
            rdata1_d = bus.mem_dout;
            cs_d     = 1'b1;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
`endif
         default: begin
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cs_q     <= 1'b1;
         wr_q     <= 1'b1;
         addr_q   <= 8'h00;
         din_q    <= 8'h00;
         rdata0_q <= 8'h00;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
`ifdef MEM_CTRL_FETCH2_EN
         fetch2_q <= 1'b0;
         rdata1_q <= 8'h00;
`endif
      end else begin
         state_q  <= state_d;
         cs_q     <= cs_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rdata0_q <= rdata0_d;
         done_q   <= done_d;
         // Registered copy of (state != IDLE) so BUSY tracks the state register.
         busy_q   <= (state_d != IDLE);
`ifdef MEM_CTRL_FETCH2_EN
         fetch2_q <= fetch2_d;
         rdata1_q <= rdata1_d;
`endif
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.rdata0   = rdata0_q;
   assign bus.mem_cs   = cs_q;
   assign bus.mem_wr   = wr_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = din_q;
`ifdef MEM_CTRL_FETCH2_EN
   assign bus.rdata1   = rdata1_q;
`else
   assign bus.rdata1   = 8'h00;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model checked every cycle, directed literal
// scenarios, then randomized requests/resets.
module tb_mem_ctrl;
`ifdef MEM_CTRL_FETCH2_EN
   localparam bit FEN = 1'b1;
`else
   localparam bit FEN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_ctrl_if bus ();
   mem_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // RAM: synchronous write on CS=0/WR=0, registered read data.
   logic [7:0] ram [256];
   logic [7:0] init_mem [256];
   bit ram_load = 1'b1;
   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_mem[i];
      end else if (!bus.mem_cs && !bus.mem_wr) begin
         ram[bus.mem_addr] <= bus.mem_din;
      end
      bus.mem_dout <= ram[bus.mem_addr];
   end

   // Transaction-level model: an accepted request completes a fixed number of edges
   // later (write 1, read 2, fetch2 4); outputs are derived from that edge count.
   logic [7:0] shadow [256];
   bit         mdl_ok = 1'b0;
   bit         active = 1'b0;
   int         cyc = 0, acc_cyc = 0, kind = 0;
   logic [7:0] a = 8'h00;
   logic       e_busy, e_done, e_cs, e_wr;
   logic [7:0] e_addr, e_din, e_r0, e_r1;

   always @(posedge clk) begin
      if (rst) begin
         if (ram_load) for (int i = 0; i < 256; i++) shadow[i] = init_mem[i];
         active = 1'b0;
         e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b1; e_wr = 1'b1;
         e_addr = 8'h00; e_din = 8'h00; e_r0 = 8'h00; e_r1 = 8'h00;
         mdl_ok = 1'b1;
      end else begin
         e_done = 1'b0;
         if (active) begin
            case (kind)
               0: if (cyc - acc_cyc == 1) begin
                  e_cs = 1'b1; e_wr = 1'b1; e_done = 1'b1; active = 1'b0;
               end
               1: if (cyc - acc_cyc == 2) begin
                  e_r0 = shadow[a]; e_cs = 1'b1; e_done = 1'b1; active = 1'b0;
               end
               default: begin
                  if (cyc - acc_cyc == 2) begin
                     e_r0 = shadow[a]; e_addr = a + 8'd1;
                  end else if (cyc - acc_cyc == 4) begin
                     e_r1 = shadow[8'(a + 8'd1)]; e_cs = 1'b1; e_done = 1'b1; active = 1'b0;
                  end
               end
            endcase
         end else if (bus.req) begin
            active = 1'b1; acc_cyc = cyc; a = bus.req_addr;
            e_cs = 1'b0; e_addr = bus.req_addr;
            if (bus.req_wr) begin
               kind = 0; e_wr = 1'b0; e_din = bus.req_wdata;
               shadow[bus.req_addr] = bus.req_wdata;
            end else begin
               kind = (FEN && bus.req_fetch2) ? 2 : 1; e_wr = 1'b1;
            end
         end
         e_busy = active;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (mdl_ok) begin
         chk("busy",   8'(bus.busy),   8'(e_busy));
         chk("done",   8'(bus.done),   8'(e_done));
         chk("mem_cs", 8'(bus.mem_cs), 8'(e_cs));
         chk("mem_wr", 8'(bus.mem_wr), 8'(e_wr));
         chk("mem_addr", bus.mem_addr, e_addr);
         chk("mem_din",  bus.mem_din,  e_din);
         chk("rdata0",   bus.rdata0,   e_r0);
         chk("rdata1",   bus.rdata1,   e_r1);
      end
   end

   // Called at a negedge with the DUT idle; returns negedges until DONE and MEM_ADDR
   // seen two edges after acceptance.
   task automatic txn(input bit wr, input bit f2, input logic [7:0] ad, input logic [7:0] wd,
                      output int lat, output logic [7:0] addr3);
      bus.req = 1'b1; bus.req_wr = wr; bus.req_fetch2 = f2;
      bus.req_addr = ad; bus.req_wdata = wd;
      lat = 0; addr3 = 8'h00;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) bus.req = 1'b0;
         if (lat == 3) addr3 = bus.mem_addr;
      end while (!bus.done && lat < 20);
      if (lat >= 20) chk("txn_timeout", 8'(lat), 8'd0);
   endtask

   int lat;
   logic [7:0] a3;
   logic [7:0] b2b_addr [3];
   logic [7:0] b2b_exp [3];

   initial begin
      bus.req = 1'b0; bus.req_wr = 1'b0; bus.req_fetch2 = 1'b0;
      bus.req_addr = 8'h00; bus.req_wdata = 8'h00;
      for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
      init_mem[0] = 8'h90; init_mem[1] = 8'h08; init_mem[2] = 8'h91; init_mem[4] = 8'h93;
      b2b_addr[0] = 8'h00; b2b_addr[1] = 8'h02; b2b_addr[2] = 8'h04;
      b2b_exp[0]  = 8'h90; b2b_exp[1]  = 8'h91; b2b_exp[2]  = 8'h93;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",  8'(bus.busy),   8'h00);
      chk("rst_cs",    8'(bus.mem_cs), 8'h01);
      chk("rst_rdata0", bus.rdata0,    8'h00);
      rst = 1'b0; ram_load = 1'b0;

      // fetch2 at 0x00
      txn(1'b0, 1'b1, 8'h00, 8'h00, lat, a3);
      chk("f2_lat", 8'(lat), FEN ? 8'd5 : 8'd3);
      chk("f2_rdata0", bus.rdata0, 8'h90);
      chk("f2_rdata1", bus.rdata1, FEN ? 8'h08 : 8'h00);

      // write 0x55 to 0x0C (fetch2 set too: still a plain write), then read back
      txn(1'b1, 1'b1, 8'h0C, 8'h55, lat, a3);
      chk("wr_lat", 8'(lat), 8'd2);
      txn(1'b0, 1'b0, 8'h0C, 8'h00, lat, a3);
      chk("rd_lat", 8'(lat), 8'd3);
      chk("rd_rdata0", bus.rdata0, 8'h55);

      // fetch2 at 0xFF wraps the second access to 0x00
      txn(1'b0, 1'b1, 8'hFF, 8'h00, lat, a3);
      chk("wrap_addr", a3, FEN ? 8'h00 : 8'hFF);

      // reset mid-fetch2 (at the fourth edge with fetch2, else one edge in)
      bus.req = 1'b1; bus.req_wr = 1'b0; bus.req_fetch2 = 1'b1; bus.req_addr = 8'h00;
      for (int k = 1; k <= (FEN ? 3 : 1); k++) begin
         @(negedge clk);
         bus.req = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_done",   8'(bus.done),   8'h00);
      chk("abort_cs",     8'(bus.mem_cs), 8'h01);
      chk("abort_busy",   8'(bus.busy),   8'h00);
      chk("abort_rdata0", bus.rdata0,     8'h00);
      chk("abort_rdata1", bus.rdata1,     8'h00);

      // REQ held high: three back-to-back single reads, DONE every 3 cycles
      bus.req = 1'b1; bus.req_wr = 1'b0; bus.req_fetch2 = 1'b0; bus.req_addr = b2b_addr[0];
      for (int k = 0; k < 3; k++) begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!bus.done && lat < 20);
         chk("b2b_gap", 8'(lat), 8'd3);
         chk("b2b_rdata0", bus.rdata0, b2b_exp[k]);
         if (k < 2) bus.req_addr = b2b_addr[k+1];
         else bus.req = 1'b0;
      end

      // randomized requests, including REQ while busy and occasional resets
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 79) == 0);
         bus.req        = ($urandom_range(0, 1) == 1);
         bus.req_wr     = ($urandom_range(0, 2) == 0);
         bus.req_fetch2 = ($urandom_range(0, 1) == 1);
         bus.req_addr   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         bus.req_wdata  = 8'($urandom);
      end
      @(negedge clk);
      rst = 1'b0; bus.req = 1'b0;
      repeat (8) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
